// File: rtl/multi_pattern_matcher_if.sv
// Byte-stream / signature-load bus for multi_pattern_matcher.
// master: packet feeder side (drives stream and signature writes).
// slave : matcher side (returns per-byte match results).
interface multi_pattern_matcher_if #(
    parameter int unsigned NUM_PAT = 4,
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned CH_W    = 8,
    parameter int unsigned CNT_W   = 16
);
    localparam int unsigned SEL_W = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1;
    localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

    logic               pat_we;
    logic [SEL_W-1:0]   pat_sel;
    logic [IDX_W-1:0]   pat_idx;
    logic [CH_W-1:0]    pat_byte;
    logic               len_we;
    logic [LEN_W-1:0]   pat_len;
    logic               in_valid;
    logic [CH_W-1:0]    in_ch;
    logic               in_clear;
    logic               match_valid;
    logic [NUM_PAT-1:0] match_vec;
    logic [SEL_W-1:0]   match_id;
    logic               ifFinal;
    logic [CNT_W-1:0]   match_cnt;

    modport master (
        output pat_we, pat_sel, pat_idx, pat_byte, len_we, pat_len,
               in_valid, in_ch, in_clear,
        input  match_valid, match_vec, match_id, ifFinal, match_cnt
    );

    modport slave (
        input  pat_we, pat_sel, pat_idx, pat_byte, len_we, pat_len,
               in_valid, in_ch, in_clear,
        output match_valid, match_vec, match_id, ifFinal, match_cnt
    );
endinterface

// File: rtl/multi_pattern_matcher.sv
// Multi-signature byte-stream matcher.
// Compares each accepted byte, together with the last MAX_LEN-1 accepted
// bytes, against NUM_PAT runtime-loaded signatures and reports every
// signature ending on that byte one cycle later.
// Optional build macro CASE_FOLD_EN: fold ASCII upper case to lower case on
// both sides before comparison (stored signatures are left untouched).
// MAX_LEN must be at least 2; CH_W must be at least 8.
module multi_pattern_matcher #(
    parameter int unsigned NUM_PAT = 4,
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned CH_W    = 8,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    multi_pattern_matcher_if.slave bus
);
    localparam int unsigned SEL_W = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1;
    localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
    localparam int unsigned HIST  = MAX_LEN - 1;

    logic [CH_W-1:0]    pat_q  [NUM_PAT][MAX_LEN];
    logic [LEN_W-1:0]   len_q  [NUM_PAT];
    logic [CH_W-1:0]    hist_q [HIST];
    logic [LEN_W-1:0]   fill_q;

    logic               valid_q;
    logic [NUM_PAT-1:0] vec_q;
    logic [SEL_W-1:0]   id_q;
    logic               final_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [CH_W-1:0]    win      [MAX_LEN];
    logic [LEN_W-1:0]   fill_eff;
    logic [LEN_W-1:0]   fill_d;
    logic [LEN_W-1:0]   len_clamp;
    logic [NUM_PAT-1:0] vec_d;
    logic [SEL_W-1:0]   id_d;
    logic [CNT_W-1:0]   cnt_d;
    logic [CNT_W:0]     pop;
    logic [CNT_W:0]     sum;
    logic               hit;
    logic [IDX_W-1:0]   pos;

    function automatic logic [CH_W-1:0] fold(input logic [CH_W-1:0] c);
        logic [CH_W-1:0] r;
        r = c;
`ifdef CASE_FOLD_EN
        if (c[7:0] >= 8'h41 && c[7:0] <= 8'h5A) r[5] = 1'b1;
`endif
        return r;
    endfunction

    // Comparison window: history (zeroed by a same-cycle clear) then the new byte.
    always_comb begin
        for (int unsigned i = 0; i < HIST; i++) begin
            win[i] = bus.in_clear ? '0 : hist_q[i];
        end
        win[MAX_LEN-1] = bus.in_ch;
        fill_eff = bus.in_clear ? '0 : fill_q;
        fill_d   = (32'(fill_eff) >= MAX_LEN) ? fill_eff : fill_eff + LEN_W'(1);
    end

    // Per-slot match: the last len[j] window characters equal the signature.
    always_comb begin
        vec_d = '0;
        hit   = 1'b0;
        pos   = '0;
        for (int unsigned j = 0; j < NUM_PAT; j++) begin
            hit = (len_q[j] != '0) && (32'(fill_eff) + 32'd1 >= 32'(len_q[j]));
            for (int unsigned k = 0; k < MAX_LEN; k++) begin
                if (k < 32'(len_q[j])) begin
                    pos = IDX_W'(MAX_LEN - 32'(len_q[j]) + k);
                    if (fold(win[pos]) != fold(pat_q[j][k])) hit = 1'b0;
                end
            end
            vec_d[j] = hit;
        end
    end

    // Lowest matching slot index and saturating running count.
    always_comb begin
        id_d = '0;
        pop  = '0;
        for (int unsigned j = NUM_PAT; j > 0; j--) begin
            if (vec_d[j-1]) id_d = SEL_W'(j - 1);
        end
        for (int unsigned j = 0; j < NUM_PAT; j++) begin
            pop = pop + (CNT_W+1)'(vec_d[j]);
        end
        sum   = {1'b0, cnt_q} + pop;
        cnt_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
        len_clamp = (32'(bus.pat_len) > MAX_LEN) ? LEN_W'(MAX_LEN) : bus.pat_len;
    end

    // Signature storage; out-of-range writes are dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned j = 0; j < NUM_PAT; j++) begin
                len_q[j] <= '0;
                for (int unsigned k = 0; k < MAX_LEN; k++) pat_q[j][k] <= '0;
            end
        end else begin
            if (bus.pat_we && 32'(bus.pat_sel) < NUM_PAT && 32'(bus.pat_idx) < MAX_LEN)
                pat_q[bus.pat_sel][bus.pat_idx] <= bus.pat_byte;
            if (bus.len_we && 32'(bus.pat_sel) < NUM_PAT)
                len_q[bus.pat_sel] <= len_clamp;
        end
    end

    // History shift register and fill counter; a clear with a byte restarts at fill 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < HIST; i++) hist_q[i] <= '0;
            fill_q <= '0;
        end else if (bus.in_valid) begin
            for (int unsigned i = 0; i < HIST; i++) hist_q[i] <= win[i+1];
            fill_q <= fill_d;
        end else if (bus.in_clear) begin
            for (int unsigned i = 0; i < HIST; i++) hist_q[i] <= '0;
            fill_q <= '0;
        end
    end

    // Registered results: valid pulses per byte, everything else holds.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            vec_q   <= '0;
            id_q    <= '0;
            final_q <= 1'b0;
            cnt_q   <= '0;
        end else if (bus.in_valid) begin
            valid_q <= 1'b1;
            vec_q   <= vec_d;
            id_q    <= id_d;
            final_q <= |vec_d;
            cnt_q   <= cnt_d;
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign bus.match_valid = valid_q;
    assign bus.match_vec   = vec_q;
    assign bus.match_id    = id_q;
    assign bus.ifFinal     = final_q;
    assign bus.match_cnt   = cnt_q;
endmodule
